rr_arbiter_8: RTL

- Round-robin arbiter sharing one resource among 8 requesters.
- Issues a registered 3-bit winner index and a one-hot 8-bit grant equal to the 3-to-8 decode of that index.
- Grant is held while the winner keeps its request asserted, with an optional hold timeout.
- Sits in front of any shared datapath selected by a 3-to-8 decoder: bus, memory port or display driver.

---
 rtl/rr_arbiter_8.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary winner index
// and an optional cap on how many consecutive cycles a single grant may be held.
module rr_arbiter_8 #(
  parameter int unsigned HOLD_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] pick;
  logic       hold_expired;

  // Returns {found, index} of the first set request scanning upward from p with wrap.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [7:0] rot;
    logic [2:0] off;
    logic       found;
    rot   = 8'({r, r} >> p);
    off   = 3'd0;
    found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) begin
        off   = 3'(k);
        found = 1'b1;
      end
    end
    return {found, p + off};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      grant_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    vld_d        = vld_q;
    pick         = rr_pick(req, ptr_q);
    hold_expired = TIMEOUT_EN && (cnt_q == HOLD_LAST);

    case (state_q)
      S_IDLE, S_RELEASE: begin
        // The release cycle arbitrates exactly like idle, but with the advanced pointer.
        if (pick[3]) begin
          state_d = S_GRANT;
          idx_d   = pick[2:0];
          vld_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end
      end
      S_GRANT: begin
        if (!req[idx_q] || hold_expired) begin
          state_d = S_RELEASE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase

    grant_d = vld_d ? (8'd1 << idx_d) : 8'd0;
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = vld_q;

endmodule
